hop_chain_seq: RTL and testbench
================================

Name: hop_chain_seq

Overview:
- Parametrised successor to the fixed per-stage-reset flop chain.
- DEPTH-stage, WIDTH-bit data pipeline with a valid bit per stage; each stage is held in reset independently.
- An internal reset sequencer releases the stages in order, stage 0 first, spaced GAP cycles apart, after rst1 or a software re-sequence request.
- Valid beats that arrive at a still-held stage are discarded and counted.
- Sits between the benchmark stimulus source and the sink, exercising staggered reset-release hops.

Parameters:
- DEPTH, 5, number of pipeline stages (>=2).
- WIDTH, 1, data width per stage (>=1).
- GAP, 2, cycles between consecutive stage releases (>=1).
- CNT_W, 8, drop counter width.

Ports:
- clock0  in  1  clock; all state updates on rising edge.
- rst1  in  1  reset, asynchronous, active-high; clock clock0.
- start  in  1  input valid for din.
- din  in  WIDTH  input data.
- reseq  in  1  synchronous re-sequence request, sampled at each edge.
- dout  out  WIDTH  data of stage DEPTH-1.
- dout_valid  out  1  valid of stage DEPTH-1.
- seq_done  out  1  all stages released.
- stage_held  out  DEPTH  bit k=1 while stage k is held.
- drop_cnt  out  CNT_W  saturating count of dropped beats.

Behaviour:
- rst1 asserted: all stage valid and data bits = 0, stage_held = all ones, seq_done = 0, drop_cnt = 0, gap counter = 0, release index = 0, FSM = SEQ_HOLD.
- FSM SEQ_HOLD:
  - gap counter increments each edge.
  - When the counter reaches GAP-1: clear stage_held[idx], reset the counter to 0, increment idx.
  - Releasing idx=DEPTH-1 moves the FSM to SEQ_DONE and sets seq_done=1 on the same edge.
- Release timing after rst1 deasserts: stage k is released on rising edge (k+1)*GAP. Example: DEPTH=5, GAP=2 -> stage 0 released at edge 2, seq_done at edge 10.
- FSM SEQ_DONE: holds until reseq.
- reseq=1 at an edge, in any state:
  - Next state is stage_held = all ones, all valid and data = 0, seq_done = 0, counter = 0, idx = 0, FSM = SEQ_HOLD.
  - reseq takes priority over a release due on the same edge.
  - Held asserted for several cycles, reseq restarts the sequence on every edge it is high.
- Held stage k: valid_k and data_k forced to 0 every edge.
- Released stage k:
  - valid_k <= valid_{k-1}, data_k <= data_{k-1}; stage -1 is (start, din).
  - Data is captured regardless of valid (plain shift).
- Latency: start/din at edge t appear on dout_valid/dout after edge t+DEPTH-1, i.e. DEPTH cycles of registering, when all stages are released.
- Drop event: source of stage k (start for k=0, else valid_{k-1}) is 1 while stage k is held at that edge.
  - Each stage counts independently.
  - drop_cnt increments by the popcount of drop events per edge, saturating at 2^CNT_W-1 with no wrap.
  - Drops are not counted on an edge where reseq=1.
- A stage released on an edge captures its source on the following edge only; the source beat present on the release edge is dropped.
- rst1 mid-sequence or mid-traffic: immediate asynchronous return to the reset state; drop_cnt cleared.

Optional Feature:
- Macro HOP_DROP_CNT_EN.
- Defined: drop detection and drop_cnt are implemented as above.
- Undefined: no counter logic; drop_cnt is tied to 0. Pipeline and sequencer behaviour are unchanged.

Decomposition:
- Package hop_pkg:
  - enum seq_state_t {SEQ_HOLD, SEQ_DONE}.
  - Function clog2-style width helper for the gap counter and idx.
- Sub-module hop_stage, one per stage, generated DEPTH times:
  - Ports: clock0, rst1, held, src_valid, src_data, valid, data, drop.
- Sequencer FSM and drop counter stay in the top.

Test Plan:
- Reset release: DEPTH=5, GAP=2, rst1 deasserts at edge 0 -> stage_held = 11110 after edge 2, 11100 after edge 4, ..., 00000 and seq_done=1 after edge 10.
- Latency: after seq_done, start=1 and din=1 for one cycle at edge t -> dout_valid=1 and dout=1 only after edge t+4; a single beat gives a single valid cycle.
- Early drop: start=1 continuously from rst1 deassert, with HOP_DROP_CNT_EN defined -> drop_cnt = total per-stage drop events computed by the bench model; no valid reaches dout before seq_done.
- Re-sequence mid-traffic: reseq=1 for one cycle while 3 beats are in flight -> next cycle stage_held = 11111, dout_valid=0, seq_done=0; sequence restarts with the edge-2 timing relative to the reseq edge.
- Saturation: CNT_W=2 and sustained drops -> drop_cnt stops at 3. rst1 pulse mid-traffic -> all outputs return to reset values asynchronously.
- Macro off: same stimulus as the early-drop test -> drop_cnt stays 0; dout and dout_valid traces identical to the macro-on run.

Source files
------------

// File: rtl/hop_pkg.sv
// Shared types and width helper for the staggered-release hop chain.
package hop_pkg;

    typedef enum logic {SEQ_HOLD, SEQ_DONE} seq_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int hop_cw(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/hop_stage.sv
// One pipeline stage: shifts its source when released, clears itself while held.
module hop_stage
    import hop_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clock0,
    input  logic             rst1,
    input  logic             held,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             drop
);

    // NOTE: non-blocking assignments keep every stage sampling its source before any stage updates.
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (held) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= src_valid;
            data  <= src_data;
        end
    end

    assign drop = src_valid & held;

endmodule

// File: rtl/hop_chain_seq.sv
// DEPTH-stage pipeline whose stages leave reset one by one, GAP cycles apart.
// Define HOP_DROP_CNT_EN to build the saturating dropped-beat counter.
module hop_chain_seq
    import hop_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int WIDTH = 1,
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clock0,
    input  logic             rst1,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             reseq,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             seq_done,
    output logic [DEPTH-1:0] stage_held,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int GAP_W = hop_cw(GAP);
    localparam int IDX_W = hop_cw(DEPTH);

    seq_state_t       state, state_nx;
    logic [GAP_W-1:0] gap_cnt;
    logic [IDX_W-1:0] idx;
    logic [DEPTH-1:0] held_r;
    logic             release_now;

    logic             valid_v [DEPTH];
    logic [WIDTH-1:0] data_v  [DEPTH];
    logic [DEPTH-1:0] drop_v;

    assign release_now = (state == SEQ_HOLD) && (gap_cnt == GAP_W'(GAP - 1));

    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) state <= SEQ_HOLD;
        else      state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        if (reseq)
            state_nx = SEQ_HOLD;
        else if (release_now && (idx == IDX_W'(DEPTH - 1)))
            state_nx = SEQ_DONE;
    end

    always_comb begin
        seq_done = (state == SEQ_DONE);
    end

    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            gap_cnt <= '0;
            idx     <= '0;
            held_r  <= '1;
        end else if (reseq) begin
            gap_cnt <= '0;
            idx     <= '0;
            held_r  <= '1;
        end else if (state == SEQ_HOLD) begin
            if (release_now) begin
                gap_cnt     <= '0;
                held_r[idx] <= 1'b0;
                idx         <= idx + 1'b1;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // A re-sequence clears every stage on the same edge, so it acts as a hold.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             src_v;
        logic [WIDTH-1:0] src_d;
        if (k == 0) begin : g_head
            assign src_v = start;
            assign src_d = din;
        end else begin : g_body
            assign src_v = valid_v[k-1];
            assign src_d = data_v[k-1];
        end
        hop_stage #(.WIDTH(WIDTH)) u_stage (
            .clock0    (clock0),
            .rst1      (rst1),
            .held      (held_r[k] | reseq),
            .src_valid (src_v),
            .src_data  (src_d),
            .valid     (valid_v[k]),
            .data      (data_v[k]),
            .drop      (drop_v[k])
        );
    end

`ifdef HOP_DROP_CNT_EN
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    logic [31:0] cnt_sum;

    always_comb begin
        cnt_sum = 32'(drop_cnt);
        for (int k = 0; k < DEPTH; k++) cnt_sum = cnt_sum + 32'(drop_v[k]);
    end

    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1)
            drop_cnt <= '0;
        else if (!reseq)
            drop_cnt <= (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end
`else
    logic unused_drop;
    assign unused_drop = ^drop_v;
    assign drop_cnt    = '0;
`endif

    assign stage_held = held_r;
    assign dout       = data_v[DEPTH-1];
    assign dout_valid = valid_v[DEPTH-1];

endmodule

// File: tb/tb_hop_chain_seq.sv
// Directed bench for hop_chain_seq: release timing, latency, drops, re-sequence, async reset.
module tb_hop_chain_seq;

    logic       clock0 = 1'b0;
    logic       rst1;
    logic       start;
    logic [0:0] din;
    logic       reseq;
    logic [0:0] dout, dout_s;
    logic       dout_valid, dout_valid_s;
    logic       seq_done, seq_done_s;
    logic [4:0] stage_held, stage_held_s;
    logic [7:0] drop_cnt;
    logic [1:0] drop_cnt_s;

    int n_cmp = 0;
    int n_bad = 0;

    hop_chain_seq #(.DEPTH(5), .WIDTH(1), .GAP(2), .CNT_W(8)) u_dut (
        .clock0(clock0), .rst1(rst1), .start(start), .din(din), .reseq(reseq),
        .dout(dout), .dout_valid(dout_valid), .seq_done(seq_done),
        .stage_held(stage_held), .drop_cnt(drop_cnt)
    );

    // Narrow-counter copy sharing all stimulus, used for saturation.
    hop_chain_seq #(.DEPTH(5), .WIDTH(1), .GAP(2), .CNT_W(2)) u_dut_sat (
        .clock0(clock0), .rst1(rst1), .start(start), .din(din), .reseq(reseq),
        .dout(dout_s), .dout_valid(dout_valid_s), .seq_done(seq_done_s),
        .stage_held(stage_held_s), .drop_cnt(drop_cnt_s)
    );

    always #5 clock0 = ~clock0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock0);
        #1;
    endtask

    // Stage k is held until edge (k+1)*GAP after the last reset/reseq edge.
    function automatic int exp_held(input int n);
        logic [4:0] r;
        for (int k = 0; k < 5; k++) r[k] = (n < (k + 1) * 2);
        return int'(r);
    endfunction

    function automatic int exp_cnt(input int v);
`ifdef HOP_DROP_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Drop totals after edges 1..12 with start held high from reset release.
    int drop_tab [12] = '{1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 6};

    initial begin
        rst1 = 1'b1; start = 1'b0; din = 1'b0; reseq = 1'b0;
        step(); step();
        check("rst_held",  int'(stage_held), 31);
        check("rst_done",  int'(seq_done), 0);
        check("rst_dv",    int'(dout_valid), 0);
        check("rst_cnt",   int'(drop_cnt), 0);

        // Release sequence with continuous traffic from the first edge.
        rst1 = 1'b0; start = 1'b1; din = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step();
            check($sformatf("rel_held_e%0d", n), int'(stage_held), exp_held(n));
            check($sformatf("rel_done_e%0d", n), int'(seq_done), int'(n >= 10));
            check($sformatf("rel_dv_e%0d", n), int'(dout_valid), int'(n >= 11));
            check($sformatf("rel_cnt_e%0d", n), int'(drop_cnt), exp_cnt(drop_tab[n-1]));
            check($sformatf("sat_cnt_e%0d", n), int'(drop_cnt_s),
                  exp_cnt(drop_tab[n-1] > 3 ? 3 : drop_tab[n-1]));
        end
        check("rel_dout", int'(dout), 1);

        // Flush, then a single beat must appear exactly four edges after capture.
        start = 1'b0; din = 1'b0;
        repeat (5) step();
        check("flush_dv", int'(dout_valid), 0);
        start = 1'b1; din = 1'b1;
        step();
        check("lat_dv_k0", int'(dout_valid), 0);
        start = 1'b0; din = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("lat_dv_k%0d", k), int'(dout_valid), int'(k == 4));
            check($sformatf("lat_dout_k%0d", k), int'(dout), int'(k == 4));
        end
        check("lat_cnt", int'(drop_cnt), exp_cnt(6));

        // Three beats in flight, then reseq held for three edges with traffic present.
        start = 1'b1; din = 1'b1;
        repeat (3) step();
        reseq = 1'b1;
        step();
        check("rsq_held", int'(stage_held), 31);
        check("rsq_dv",   int'(dout_valid), 0);
        check("rsq_done", int'(seq_done), 0);
        check("rsq_cnt",  int'(drop_cnt), exp_cnt(6));
        repeat (2) step();
        check("rsq_cnt_hold", int'(drop_cnt), exp_cnt(6));
        check("rsq_held_hold", int'(stage_held), 31);
        reseq = 1'b0; start = 1'b0; din = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            check($sformatf("rsq_held_e%0d", n), int'(stage_held), exp_held(n));
            check($sformatf("rsq_done_e%0d", n), int'(seq_done), int'(n >= 10));
        end
        check("rsq_cnt_end", int'(drop_cnt), exp_cnt(6));

        // Traffic reaches the output, then an asynchronous reset mid-cycle.
        start = 1'b1; din = 1'b1;
        repeat (6) step();
        check("pre_rst_dv", int'(dout_valid), 1);
        #2 rst1 = 1'b1;
        #1;
        check("arst_held", int'(stage_held), 31);
        check("arst_dv",   int'(dout_valid), 0);
        check("arst_dout", int'(dout), 0);
        check("arst_done", int'(seq_done), 0);
        check("arst_cnt",  int'(drop_cnt), 0);
        check("arst_sat",  int'(drop_cnt_s), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
